// File: rtl/main_system_nios2_fft_cpu_ocimem_cmd_exec.sv
// ---------------------------------------------------------------------------
// main_system_nios2_fft_cpu_ocimem_cmd_exec
//
// Executes JTAG debug-slave commands against the OCI debug RAM. The block
// keeps an auto-incrementing word address (MonAReg), a write-data register
// and the last read word (MonDReg). It issues single RAM read/write
// requests that are held until the RAM accepts them (mem_wait low).
//
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   jdo[37:0]                JTAG data, valid while a take_* strobe is high
//   take_action_ocimem_a     load address jdo[ADDR_W+16:17]; jdo[35] also
//                            starts a read; jdo[36] clears monitor_error
//   take_action_ocimem_b     write jdo[34:3] at the address, then increment
//   take_no_action_ocimem_a  read at the address, then increment
//   mem_addr/mem_wdata       RAM word address / write data
//   mem_wr/mem_rd            RAM write / read request
//   mem_wait                 RAM stall; request accepted when low
//   mem_rdata                read data, valid one cycle after acceptance
//   MonDReg                  last read data
//   monitor_ready            idle and able to take a command
//   monitor_error            sticky error flag
//
// Parameters: ADDR_W (RAM word-address width), TIMEOUT_CYCLES (stall limit).
// Optional feature macro: OCIMEM_CMD_TIMEOUT_EN -- when defined, a request
// stalled for TIMEOUT_CYCLES cycles is dropped and monitor_error is set.
// ---------------------------------------------------------------------------
module main_system_nios2_fft_cpu_ocimem_cmd_exec #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic              mem_wait,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] monAReg_q, monAReg_d;
  logic [31:0]       monDReg_q, monDReg_d;
  logic [31:0]       wData_q, wData_d;
  logic              error_q, error_d;
  logic              setErr;
  logic              clrErr;
  logic              anyStrobe;
  logic              timeoutHit;
  logic              unusedJdo;

  // jdo bits outside the address, data and flag fields carry nothing here.
  assign unusedJdo = ^{jdo[37], jdo[2:0]};

  assign anyStrobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

`ifdef OCIMEM_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inReq;

  assign inReq      = (state_q == RD_REQ) || (state_q == WR_REQ);
  // The abort fires on the edge that ends the TIMEOUT_CYCLES-th stalled cycle.
  assign timeoutHit = inReq && mem_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: runs only while a request is held off, restarts otherwise.
  always_comb begin
    cnt_d = '0;
    if (inReq && mem_wait && !timeoutHit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unusedTimeout = TIMEOUT_CYCLES;

  assign timeoutHit = 1'b0;
`endif

  // State and register file; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      monAReg_q <= '0;
      monDReg_q <= '0;
      wData_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      monAReg_q <= monAReg_d;
      monDReg_q <= monDReg_d;
      wData_q   <= wData_d;
      error_q   <= error_d;
    end
  end

  // Command decode and transaction sequencing. Strobes outside IDLE, and
  // lower-priority strobes colliding in IDLE, are dropped and flag an error.
  always_comb begin
    state_d   = state_q;
    monAReg_d = monAReg_q;
    monDReg_d = monDReg_q;
    wData_d   = wData_q;
    setErr    = 1'b0;
    clrErr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          monAReg_d = jdo[ADDR_W+16:17];
          state_d   = jdo[35] ? RD_REQ : IDLE;
          clrErr    = jdo[36];
          setErr    = take_action_ocimem_b | take_no_action_ocimem_a;
        end else if (take_action_ocimem_b) begin
          wData_d = jdo[34:3];
          state_d = WR_REQ;
          setErr  = take_no_action_ocimem_a;
        end else if (take_no_action_ocimem_a) begin
          state_d = RD_REQ;
        end
      end

      RD_REQ: begin
        setErr = anyStrobe;
        if (timeoutHit) begin
          state_d = IDLE;
          setErr  = 1'b1;
        end else if (!mem_wait) begin
          state_d = RD_DATA;
        end
      end

      RD_DATA: begin
        setErr    = anyStrobe;
        monDReg_d = mem_rdata;
        monAReg_d = monAReg_q + ADDR_W'(1);
        state_d   = IDLE;
      end

      WR_REQ: begin
        setErr = anyStrobe;
        if (timeoutHit) begin
          state_d = IDLE;
          setErr  = 1'b1;
        end else if (!mem_wait) begin
          monAReg_d = monAReg_q + ADDR_W'(1);
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A clear in the same cycle as a dropped strobe still leaves the flag set.
    if (clrErr) begin
      error_d = setErr;
    end else begin
      error_d = error_q | setErr;
    end
  end

  assign mem_addr      = monAReg_q;
  assign mem_wdata     = wData_q;
  assign mem_rd        = (state_q == RD_REQ);
  assign mem_wr        = (state_q == WR_REQ);
  assign MonDReg       = monDReg_q;
  assign monitor_ready = (state_q == IDLE);
  assign monitor_error = error_q;

endmodule

// File: tb/tb_main_system_nios2_fft_cpu_ocimem_cmd_exec.sv
// Directed bench for the OCI memory command executor. Inputs are driven 1ns
// after each rising edge and outputs are checked at the same point.
module tb_main_system_nios2_fft_cpu_ocimem_cmd_exec;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic        mem_wait;
  logic [31:0] mem_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int checkCount = 0;
  int failCount  = 0;

  main_system_nios2_fft_cpu_ocimem_cmd_exec #(
    .ADDR_W(8),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wr(mem_wr),
    .mem_rd(mem_rd),
    .mem_wait(mem_wait),
    .mem_rdata(mem_rdata),
    .MonDReg(MonDReg),
    .monitor_ready(monitor_ready),
    .monitor_error(monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of strobes with the given jdo, then releases them.
  task automatic applyStimulus(input logic a, input logic b, input logic n, input logic [37:0] j);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = n;
    jdo                     = j;
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo                     = '0;
  endtask

  function automatic logic [37:0] jdoA(input logic clr, input logic rd, input logic [7:0] addr);
    logic [37:0] j;
    j        = '0;
    j[36]    = clr;
    j[35]    = rd;
    j[24:17] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdoB(input logic [31:0] data);
    logic [37:0] j;
    j       = '0;
    j[34:3] = data;
    return j;
  endfunction

  initial begin
    int waited;
    reset                   = 1'b1;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    mem_wait                = 1'b0;
    mem_rdata               = 32'h0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_ready", monitor_ready, 1);
    checkOutput("rst_rd", mem_rd, 0);
    checkOutput("rst_wr", mem_wr, 0);
    checkOutput("rst_addr", mem_addr, 8'h00);
    checkOutput("rst_mondreg", MonDReg, 32'h0);
    checkOutput("rst_error", monitor_error, 0);
    reset = 1'b0;
    tick();

    // Address load then read, no stall: MonDReg updates on the third edge
    mem_rdata = 32'hBAD0BAD0;
    applyStimulus(1, 0, 0, jdoA(0, 1, 8'h10));
    checkOutput("rd1_req_rd", mem_rd, 1);
    checkOutput("rd1_req_addr", mem_addr, 8'h10);
    checkOutput("rd1_req_ready", monitor_ready, 0);
    tick();
    mem_rdata = 32'hDEADBEEF;
    checkOutput("rd1_data_rd", mem_rd, 0);
    checkOutput("rd1_data_early", MonDReg, 32'h0);
    tick();
    mem_rdata = 32'h0BADC0DE;
    checkOutput("rd1_mondreg", MonDReg, 32'hDEADBEEF);
    checkOutput("rd1_addr_inc", mem_addr, 8'h11);
    checkOutput("rd1_ready", monitor_ready, 1);

    // Write with four stall cycles: request held five cycles at 0x11
    mem_wait = 1'b1;
    applyStimulus(0, 1, 0, jdoB(32'h12345678));
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_wait = 1'b0;
      checkOutput($sformatf("wr_hold%0d_wr", i), mem_wr, 1);
      checkOutput($sformatf("wr_hold%0d_addr", i), mem_addr, 8'h11);
      checkOutput($sformatf("wr_hold%0d_data", i), mem_wdata, 32'h12345678);
      tick();
    end
    checkOutput("wr_done_wr", mem_wr, 0);
    checkOutput("wr_done_addr", mem_addr, 8'h12);
    checkOutput("wr_done_ready", monitor_ready, 1);

    // Address wrap from 0xFF to 0x00
    applyStimulus(1, 0, 0, jdoA(0, 0, 8'hFF));
    checkOutput("wrap_load_addr", mem_addr, 8'hFF);
    checkOutput("wrap_load_rd", mem_rd, 0);
    checkOutput("wrap_load_ready", monitor_ready, 1);
    mem_rdata = 32'hCAFEF00D;
    applyStimulus(0, 0, 1, '0);
    checkOutput("wrap_req_rd", mem_rd, 1);
    checkOutput("wrap_req_addr", mem_addr, 8'hFF);
    tick();
    tick();
    checkOutput("wrap_mondreg", MonDReg, 32'hCAFEF00D);
    checkOutput("wrap_addr", mem_addr, 8'h00);
    checkOutput("wrap_error", monitor_error, 0);

    // All three strobes in IDLE: address load wins, others flag an error
    applyStimulus(1, 1, 1, jdoA(0, 0, 8'h40));
    checkOutput("prio3_addr", mem_addr, 8'h40);
    checkOutput("prio3_wr", mem_wr, 0);
    checkOutput("prio3_ready", monitor_ready, 1);
    checkOutput("prio3_error", monitor_error, 1);
    applyStimulus(1, 0, 0, jdoA(1, 0, 8'h20));
    checkOutput("clr1_error", monitor_error, 0);
    checkOutput("clr1_addr", mem_addr, 8'h20);

    // Write beats read-increment when both strobe together
    applyStimulus(0, 1, 1, jdoB(32'hA5A5A5A5));
    checkOutput("prio2_wr", mem_wr, 1);
    checkOutput("prio2_rd", mem_rd, 0);
    checkOutput("prio2_wdata", mem_wdata, 32'hA5A5A5A5);
    checkOutput("prio2_error", monitor_error, 1);
    tick();
    checkOutput("prio2_addr", mem_addr, 8'h21);
    applyStimulus(1, 0, 0, jdoA(1, 0, 8'h30));
    checkOutput("clr2_error", monitor_error, 0);

    // Busy collision during a stalled read
    mem_wait  = 1'b1;
    mem_rdata = 32'h0;
    applyStimulus(0, 0, 1, '0);
    checkOutput("busy_rd", mem_rd, 1);
    applyStimulus(0, 1, 0, jdoB(32'h11111111));
    checkOutput("busy_error", monitor_error, 1);
    checkOutput("busy_wr", mem_wr, 0);
    checkOutput("busy_still_rd", mem_rd, 1);
    applyStimulus(1, 0, 0, jdoA(0, 1, 8'h77));
    checkOutput("busy_addr_kept", mem_addr, 8'h30);
    mem_wait = 1'b0;
    tick();
    mem_rdata = 32'h600DF00D;
    checkOutput("busy_data_wr", mem_wr, 0);
    tick();
    mem_rdata = 32'h0;
    checkOutput("busy_mondreg", MonDReg, 32'h600DF00D);
    checkOutput("busy_addr_inc", mem_addr, 8'h31);
    checkOutput("busy_done_wr", mem_wr, 0);
    checkOutput("busy_error_sticky", monitor_error, 1);
    applyStimulus(1, 0, 0, jdoA(1, 0, 8'h31));
    checkOutput("busy_clr", monitor_error, 0);

    // Reset during a stalled write
    mem_wait = 1'b1;
    applyStimulus(0, 1, 0, jdoB(32'hFFFFFFFF));
    checkOutput("rstwr_wr", mem_wr, 1);
    applyStimulus(0, 0, 1, '0);
    checkOutput("rstwr_error", monitor_error, 1);
    reset = 1'b1;
    tick();
    checkOutput("rstwr_wr_off", mem_wr, 0);
    checkOutput("rstwr_ready", monitor_ready, 1);
    checkOutput("rstwr_addr", mem_addr, 8'h00);
    checkOutput("rstwr_wdata", mem_wdata, 32'h0);
    checkOutput("rstwr_mondreg", MonDReg, 32'h0);
    checkOutput("rstwr_error0", monitor_error, 0);
    reset    = 1'b0;
    mem_wait = 1'b0;
    tick();
    checkOutput("post_rst_wr", mem_wr, 0);
    checkOutput("post_rst_rd", mem_rd, 0);
    checkOutput("post_rst_addr", mem_addr, 8'h00);

`ifdef OCIMEM_CMD_TIMEOUT_EN
    // Stuck stall: the read is dropped after 255 waiting cycles
    mem_wait = 1'b1;
    applyStimulus(1, 0, 0, jdoA(0, 1, 8'h55));
    waited = 0;
    while (!monitor_ready && waited < 400) begin
      tick();
      waited++;
    end
    checkOutput("tmo_cycles", waited, 255);
    checkOutput("tmo_error", monitor_error, 1);
    checkOutput("tmo_rd", mem_rd, 0);
    checkOutput("tmo_addr", mem_addr, 8'h55);
    checkOutput("tmo_mondreg", MonDReg, 32'h0);
    mem_wait = 1'b0;
`else
    waited = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
